// File: rtl/dcpu_bus_arbiter_if.sv
// Bus bundle between the dcpu arbiter, its two masters and the memory.
// The slave modport is the arbiter side; the master modport drives requests and memory data.
interface dcpu_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          i_m0_req;
  logic [AW-1:0] i_m0_addr;
  logic [DW-1:0] i_m0_dat;
  logic          i_m0_rw;
  logic          o_m0_ack;
  logic [DW-1:0] o_m0_dat;

  logic          i_m1_req;
  logic [AW-1:0] i_m1_addr;
  logic [DW-1:0] i_m1_dat;
  logic          i_m1_rw;
  logic          o_m1_ack;
  logic [DW-1:0] o_m1_dat;

  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_dat;
  logic          o_mem_rw;
  logic          o_mem_en;
  logic [DW-1:0] i_mem_dat;

  modport slave (
    input  i_m0_req, i_m0_addr, i_m0_dat, i_m0_rw,
    output o_m0_ack, o_m0_dat,
    input  i_m1_req, i_m1_addr, i_m1_dat, i_m1_rw,
    output o_m1_ack, o_m1_dat,
    output o_mem_addr, o_mem_dat, o_mem_rw, o_mem_en,
    input  i_mem_dat
  );

  modport master (
    output i_m0_req, i_m0_addr, i_m0_dat, i_m0_rw,
    input  o_m0_ack, o_m0_dat,
    output i_m1_req, i_m1_addr, i_m1_dat, i_m1_rw,
    input  o_m1_ack, o_m1_dat,
    input  o_mem_addr, o_mem_dat, o_mem_rw, o_mem_en,
    output i_mem_dat
  );
endinterface

// File: rtl/dcpu_bus_arbiter.sv
// Two-master arbiter for the dcpu memory bus: parks on the CPU (M0), and a hold
// counter caps consecutive grants to one owner while the other master waits.
module dcpu_bus_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_HOLD = 4
) (
  input logic                i_clk,
  input logic                i_reset_n,
  dcpu_bus_arbiter_if.slave  bus
);
  localparam int HW = $clog2(MAX_HOLD) + 1;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          owner_m1;
  logic          own_req, other_req;
  state_t        other_state;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
    end
  end

  always_comb begin
    state_n     = state;
    hold_n      = '0;
    own_req     = 1'b0;
    other_req   = 1'b0;
    other_state = OWN0;
    unique case (state)
      IDLE: begin
        if (bus.i_m0_req)      state_n = OWN0;
        else if (bus.i_m1_req) state_n = OWN1;
      end
      OWN0, OWN1: begin
        own_req     = (state == OWN0) ? bus.i_m0_req : bus.i_m1_req;
        other_req   = (state == OWN0) ? bus.i_m1_req : bus.i_m0_req;
        other_state = (state == OWN0) ? OWN1 : OWN0;
        if (own_req && other_req) begin
          // Compare with >= so the counter can never run past the limit.
          if (hold_cnt >= HW'(MAX_HOLD - 1)) state_n = other_state;
          else                               hold_n  = hold_cnt + HW'(1);
        end else if (!own_req) begin
          state_n = other_req ? other_state : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // IDLE and OWN0 both leave the bus parked on M0.
  assign owner_m1 = (state == OWN1);

  always_comb begin
    bus.o_m0_ack   = i_reset_n & ~owner_m1 & bus.i_m0_req;
    bus.o_m1_ack   = i_reset_n &  owner_m1 & bus.i_m1_req;
    bus.o_mem_en   = bus.o_m0_ack | bus.o_m1_ack;
    bus.o_mem_addr = owner_m1 ? bus.i_m1_addr : bus.i_m0_addr;
    bus.o_mem_dat  = owner_m1 ? bus.i_m1_dat  : bus.i_m0_dat;
    bus.o_mem_rw   = 1'b1;
    if (bus.o_mem_en) bus.o_mem_rw = owner_m1 ? bus.i_m1_rw : bus.i_m0_rw;
    bus.o_m0_dat   = bus.i_mem_dat;
    bus.o_m1_dat   = bus.i_mem_dat;
  end
endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// Directed scoreboard bench for dcpu_bus_arbiter with a word-addressed memory model.
module tb_dcpu_bus_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dcpu_bus_arbiter_if #(.AW(16), .DW(16)) bus ();

  dcpu_bus_arbiter #(.AW(16), .DW(16), .MAX_HOLD(4)) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus)
  );

  logic [15:0] mem [0:65535];
  bit          mem_ready;
  logic        pl_en;
  logic [15:0] pl_a, pl_d;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) mem[i] <= '0;
      mem_ready <= 1'b1;
    end else if (pl_en) begin
      mem[pl_a] <= pl_d;
    end else if (bus.o_mem_en && !bus.o_mem_rw) begin
      mem[bus.o_mem_addr] <= bus.o_mem_dat;
    end
  end

  assign bus.i_mem_dat = mem[bus.o_mem_addr];

  typedef struct {
    string       tag;
    logic        a0, a1, rw;
    logic [2:0]  chk;    // bit0 addr, bit1 write data, bit2 read data of acked master
    logic [15:0] addr, wdat, rdat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input logic a0, input logic a1, input logic rw,
                      input logic [2:0] c, input logic [15:0] addr, input logic [15:0] wdat,
                      input logic [15:0] rdat);
    exp_t e;
    e.tag = tag; e.a0 = a0; e.a1 = a1; e.rw = rw; e.chk = c;
    e.addr = addr; e.wdat = wdat; e.rdat = rdat;
    exp_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL sb_underflow observed=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, ".m0_ack"}, 16'(bus.o_m0_ack), 16'(e.a0));
      chk({e.tag, ".m1_ack"}, 16'(bus.o_m1_ack), 16'(e.a1));
      chk({e.tag, ".mem_en"}, 16'(bus.o_mem_en), 16'(e.a0 | e.a1));
      chk({e.tag, ".mem_rw"}, 16'(bus.o_mem_rw), 16'(e.rw));
      if (e.chk[0]) chk({e.tag, ".addr"}, bus.o_mem_addr, e.addr);
      if (e.chk[1]) chk({e.tag, ".wdat"}, bus.o_mem_dat, e.wdat);
      if (e.chk[2]) chk({e.tag, ".rdat"}, e.a0 ? bus.o_m0_dat : bus.o_m1_dat, e.rdat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic req, input logic [15:0] a, input logic [15:0] d, input logic rw);
    bus.i_m0_req = req; bus.i_m0_addr = a; bus.i_m0_dat = d; bus.i_m0_rw = rw;
  endtask

  task automatic drv1(input logic req, input logic [15:0] a, input logic [15:0] d, input logic rw);
    bus.i_m1_req = req; bus.i_m1_addr = a; bus.i_m1_dat = d; bus.i_m1_rw = rw;
  endtask

  initial begin
    pl_en = 1'b0; pl_a = '0; pl_d = '0;

    // 1: reset with both requesting writes, then parked idle, then zero-latency M0
    reset_n = 1'b0;
    drv0(1'b1, 16'h0100, 16'hAAAA, 1'b0);
    drv1(1'b1, 16'h0300, 16'hBBBB, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push("t1.rst", 1'b0, 1'b0, 1'b1, 3'b000, '0, '0, '0);
      step();
    end
    reset_n = 1'b1;
    drv0(1'b0, 16'h0100, 16'hAAAA, 1'b1);
    drv1(1'b0, 16'h0300, 16'hBBBB, 1'b1);
    push("t1.park", 1'b0, 1'b0, 1'b1, 3'b001, 16'h0100, '0, '0);
    step();
    drv0(1'b1, 16'h0100, 16'h0000, 1'b1);
    push("t1.m0", 1'b1, 1'b0, 1'b1, 3'b001, 16'h0100, '0, '0);
    step();
    drv0(1'b0, 16'h0100, 16'h0000, 1'b1);
    push("t1.rel", 1'b0, 1'b0, 1'b1, 3'b000, '0, '0, '0);
    step();

    // 2: M1 solo write from IDLE takes one cycle to win the bus
    drv1(1'b1, 16'h1234, 16'hBEEF, 1'b0);
    push("t2.c0", 1'b0, 1'b0, 1'b1, 3'b000, '0, '0, '0);
    step();
    push("t2.c1", 1'b0, 1'b1, 1'b0, 3'b011, 16'h1234, 16'hBEEF, '0);
    step();
    chk("t2.mem", mem[16'h1234], 16'hBEEF);
    drv1(1'b0, 16'h1234, 16'hBEEF, 1'b1);
    push("t2.rel", 1'b0, 1'b0, 1'b1, 3'b000, '0, '0, '0);
    step();

    // 3: M0 takes the bus, then 16 contended cycles alternate in runs of four
    drv0(1'b1, 16'h0010, 16'h0000, 1'b1);
    push("t3.pre", 1'b1, 1'b0, 1'b1, 3'b001, 16'h0010, '0, '0);
    step();
    drv1(1'b1, 16'h0020, 16'h0000, 1'b1);
    for (int k = 0; k < 16; k++) begin
      if (((k / 4) % 2) == 0)
        push($sformatf("t3.k%0d", k), 1'b1, 1'b0, 1'b1, 3'b001, 16'h0010, '0, '0);
      else
        push($sformatf("t3.k%0d", k), 1'b0, 1'b1, 1'b1, 3'b001, 16'h0020, '0, '0);
      step();
    end
    drv0(1'b0, 16'h0010, 16'h0000, 1'b1);
    drv1(1'b0, 16'h0020, 16'h0000, 1'b1);
    push("t3.rel", 1'b0, 1'b0, 1'b1, 3'b000, '0, '0, '0);
    step();

    // 4: M1 owns, releases while M0 waits: one dead cycle, fresh hold count for M0
    drv1(1'b1, 16'h0030, 16'h0000, 1'b1);
    push("t4.c0", 1'b0, 1'b0, 1'b1, 3'b000, '0, '0, '0);
    step();
    push("t4.m1", 1'b0, 1'b1, 1'b1, 3'b001, 16'h0030, '0, '0);
    step();
    drv1(1'b0, 16'h0030, 16'h0000, 1'b1);
    drv0(1'b1, 16'h0040, 16'h0000, 1'b1);
    push("t4.dead", 1'b0, 1'b0, 1'b1, 3'b000, '0, '0, '0);
    step();
    drv1(1'b1, 16'h0030, 16'h0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      push($sformatf("t4.m0_%0d", k), 1'b1, 1'b0, 1'b1, 3'b001, 16'h0040, '0, '0);
      step();
    end
    push("t4.sw", 1'b0, 1'b1, 1'b1, 3'b001, 16'h0030, '0, '0);
    step();
    drv0(1'b0, 16'h0040, 16'h0000, 1'b1);
    drv1(1'b0, 16'h0030, 16'h0000, 1'b1);
    push("t4.rel", 1'b0, 1'b0, 1'b1, 3'b000, '0, '0, '0);
    step();

    // 5: simultaneous requests from IDLE; M0 wins the tie and reads preloaded data
    pl_en = 1'b1; pl_a = 16'h00F0; pl_d = 16'h5A5A;
    push("t5.pl", 1'b0, 1'b0, 1'b1, 3'b000, '0, '0, '0);
    step();
    pl_en = 1'b0;
    drv0(1'b1, 16'h00F0, 16'h0000, 1'b1);
    drv1(1'b1, 16'h0042, 16'h0000, 1'b1);
    push("t5.c0", 1'b1, 1'b0, 1'b1, 3'b101, 16'h00F0, '0, 16'h5A5A);
    step();
    drv0(1'b0, 16'h00F0, 16'h0000, 1'b1);
    push("t5.c1", 1'b0, 1'b0, 1'b1, 3'b000, '0, '0, '0);
    step();
    push("t5.c2", 1'b0, 1'b1, 1'b1, 3'b001, 16'h0042, '0, '0);
    step();
    drv1(1'b0, 16'h0042, 16'h0000, 1'b1);
    push("t5.rel", 1'b0, 1'b0, 1'b1, 3'b000, '0, '0, '0);
    step();

    // 6: reset in the middle of an M1 write burst drops the grant and the write
    drv1(1'b1, 16'h0200, 16'h1111, 1'b0);
    push("t6.c0", 1'b0, 1'b0, 1'b1, 3'b000, '0, '0, '0);
    step();
    push("t6.w0", 1'b0, 1'b1, 1'b0, 3'b011, 16'h0200, 16'h1111, '0);
    step();
    drv1(1'b1, 16'h0201, 16'h2222, 1'b0);
    reset_n = 1'b0;
    push("t6.rst", 1'b0, 1'b0, 1'b1, 3'b000, '0, '0, '0);
    step();
    reset_n = 1'b1;
    drv0(1'b1, 16'h0100, 16'h0000, 1'b1);
    push("t6.post", 1'b1, 1'b0, 1'b1, 3'b001, 16'h0100, '0, '0);
    step();
    chk("t6.mem0", mem[16'h0200], 16'h1111);
    chk("t6.mem1", mem[16'h0201], 16'h0000);
    drv0(1'b0, 16'h0100, 16'h0000, 1'b1);
    drv1(1'b0, 16'h0201, 16'h2222, 1'b1);
    push("t6.rel", 1'b0, 1'b0, 1'b1, 3'b000, '0, '0, '0);
    step();

    n_chk++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
